cpu_clk_ctrl: RTL and testbench
===============================

Name: cpu_clk_ctrl

Overview:
- Sequences the 6502 PHI0 clock generated inside the decoder FPGA from the 50 MHz source.
- Produces PHI0 as a phase state machine, not a free counter compare.
- Stretches the PHI0 high phase when a slow device is selected.
- Supports halting and single-stepping the CPU for bring-up and debug.

Parameters:
- DIVISOR, 6, source clocks per unstretched PHI0 period (legal range 2..255). HIGH_LEN = DIVISOR/2 (floor); LOW_LEN = DIVISOR - HIGH_LEN.
- WAIT_CYCLES, 6, extra source clocks added to the high phase per slow access (legal range 0..255). A value of 0 disables stretching.

Ports:
- CLK_SRC  in  1  50 MHz source clock. Every register uses its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- SLOW_CS  in  1  high when the upcoming access targets a slow device. Externally synchronous to CLK_SRC.
- RUN      in  1  1 = free-run; 0 = halt at the end of the current cycle.
- STEP     in  1  while halted, a rising edge runs exactly one PHI0 cycle.
- PHI0     out 1  CPU clock, registered.
- CYCLE_END out 1  one-CLK_SRC pulse on the first low-phase clock, coincident with the PHI0 falling edge.
- HALTED   out 1  high while the FSM is in HALT.
- STRETCHING out 1  high during the stretched part of the high phase.

Behaviour:
- Reset state: FSM=HIGH, cnt=0, PHI0=1, CYCLE_END=0, HALTED=0, STRETCHING=0, step edge register=0.
- Reset mid-operation, including mid-stretch or in HALT, forces these values immediately. The first full high phase starts on the first clock after RESET_N rises.
- FSM states: HIGH, STRETCH, LOW, HALT. PHI0=1 in HIGH and STRETCH; PHI0=0 in LOW and HALT. All outputs are registered and have zero combinational paths.
- HIGH: cnt counts 0..HIGH_LEN-1.
  - At HIGH_LEN-1, go to STRETCH if slow_lat=1 and WAIT_CYCLES>0; otherwise go to LOW.
  - cnt resets to 0 on every state change.
- STRETCH: lasts WAIT_CYCLES clocks with STRETCHING=1, then go to LOW.
- LOW: lasts LOW_LEN clocks. CYCLE_END=1 on the first LOW clock only.
  - On the last LOW clock, if RUN=1 (or a pending step has just been consumed with RUN=1), go to HIGH.
  - Otherwise go to HALT.
- HALT: PHI0 holds 0 and HALTED=1.
  - Leave to HIGH on the clock after RUN=1, or after a STEP rising edge (STEP & ~step_q).
  - HALTED drops on the same clock PHI0 rises.
- A step runs one full HIGH(+STRETCH)+LOW period and re-enters HALT if RUN=0.
- STEP edges seen outside HALT are ignored, not queued.
- slow_lat captures SLOW_CS on the clock the FSM enters HIGH, whether from LOW, from HALT or out of reset. It is held for that cycle. SLOW_CS changes mid-cycle have no effect.
- RUN is sampled only on the last LOW clock; RUN deasserting mid-cycle never truncates a phase.
- If RUN=0 and slow_lat=1 together: the stretch completes first, then the FSM halts at the end of LOW.
- Counter width is $clog2(256); counts never wrap within legal parameter ranges.
- Nominal timing:
  - DIVISOR=6 gives 3 high + 3 low clocks, 8.33 MHz.
  - A slow cycle gives 9 high + 3 low clocks.
  - DIVISOR=5 gives 2 high + 3 low clocks.

Optional Feature:
- Macro: CPU_CLK_STEP_EN.
- Defined: HALT state, RUN/STEP handling and HALTED behave as above.
- Undefined:
  - HALT logic is not synthesised; RUN and STEP are ignored.
  - LOW always proceeds to HIGH; HALTED is tied to 0.
  - Stretching and CYCLE_END are unchanged.

Test Plan:
- Reset check: assert RESET_N=0 mid-STRETCH -> PHI0=1, STRETCHING=0, CYCLE_END=0, HALTED=0 immediately. After release, the first high phase is 3 clocks.
- Free-run: RUN=1, SLOW_CS=0, DIVISOR=6 -> PHI0 period 6 clocks, high 3, low 3. CYCLE_END pulses once per period, 1 clock wide, on the falling edge.
- Slow access: SLOW_CS=1 at HIGH entry -> high lasts 9 clocks, STRETCHING high for clocks 4-9. SLOW_CS toggling mid-cycle -> no change to that cycle.
- Halt: drop RUN mid-high phase -> current cycle completes (3+3), then PHI0=0 and HALTED=1 indefinitely.
- Step: while halted, pulse STEP for 5 clocks -> exactly one 6-clock PHI0 period and one CYCLE_END, then HALT again. A second STEP edge gives one more period.
- Odd divisor plus macro off: DIVISOR=5, CPU_CLK_STEP_EN undefined, RUN=0 -> runs continuously, high 2, low 3, HALTED=0.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: 6502 PHI0 phase sequencer with slow-device stretching.
// Define CPU_CLK_STEP_EN to build the HALT state with RUN/STEP halt and single-step control.
module cpu_clk_ctrl #(
    parameter int DIVISOR     = 6,
    parameter int WAIT_CYCLES = 6
) (
    input  logic CLK_SRC,
    input  logic RESET_N,
    input  logic SLOW_CS,
    input  logic RUN,
    input  logic STEP,
    output logic PHI0,
    output logic CYCLE_END,
    output logic HALTED,
    output logic STRETCHING
);
    localparam int CW = $clog2(256);
    localparam logic [CW-1:0] HIGH_LAST = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] LOW_LAST  = CW'(DIVISOR - DIVISOR / 2 - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_HIGH, S_STRETCH, S_LOW, S_HALT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          slow_q, slow_d;
    logic          phi_q, cend_q, stretch_q;
    logic          run_on, step_go;

`ifdef CPU_CLK_STEP_EN
    logic step_q, halted_q;
    assign run_on  = RUN;
    assign step_go = STEP & ~step_q;
    assign HALTED  = halted_q;
    always_ff @(posedge CLK_SRC or negedge RESET_N) begin
        if (!RESET_N) begin
            step_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= STEP;
            halted_q <= state_d == S_HALT;
        end
    end
`else
    logic unused_in;
    assign unused_in = RUN ^ STEP;
    assign run_on    = 1'b1;
    assign step_go   = 1'b0;
    assign HALTED    = 1'b0;
`endif

    // slow_lat is taken on the first HIGH clock and used live there, so HIGH_LEN=1 still works
    assign slow_d = (state_q == S_HIGH && cnt_q == '0) ? SLOW_CS : slow_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HIGH:    if (cnt_q == HIGH_LAST) state_d = (slow_d && WAIT_CYCLES > 0) ? S_STRETCH : S_LOW;
            S_STRETCH: if (cnt_q == WAIT_LAST) state_d = S_LOW;
            S_LOW:     if (cnt_q == LOW_LAST)  state_d = run_on ? S_HIGH : S_HALT;
            default:   if (run_on || step_go)  state_d = S_HIGH;
        endcase
        cnt_d = (state_d != state_q || state_q == S_HALT) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge CLK_SRC or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_HIGH;
            cnt_q     <= '0;
            slow_q    <= 1'b0;
            phi_q     <= 1'b1;
            cend_q    <= 1'b0;
            stretch_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            slow_q    <= slow_d;
            phi_q     <= state_d == S_HIGH || state_d == S_STRETCH;
            cend_q    <= state_d == S_LOW && state_q != S_LOW;
            stretch_q <= state_d == S_STRETCH;
        end
    end

    assign PHI0       = phi_q;
    assign CYCLE_END  = cend_q;
    assign STRETCHING = stretch_q;
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: two instances (DIVISOR 6/WAIT 6 and DIVISOR 5/WAIT 0) checked every cycle
// against a period-position model, plus hand-computed phase lengths.
module tb_cpu_clk_ctrl;
    localparam int D0 = 6, W0 = 6, D1 = 5, W1 = 0;
`ifdef CPU_CLK_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic clk, rst_n, slow_cs, run, step;
    logic [1:0] phi, cend, halted, stretching;
    int errors = 0, checks = 0;

    cpu_clk_ctrl #(.DIVISOR(D0), .WAIT_CYCLES(W0)) u_dut0 (
        .CLK_SRC(clk), .RESET_N(rst_n), .SLOW_CS(slow_cs), .RUN(run), .STEP(step),
        .PHI0(phi[0]), .CYCLE_END(cend[0]), .HALTED(halted[0]), .STRETCHING(stretching[0]));
    cpu_clk_ctrl #(.DIVISOR(D1), .WAIT_CYCLES(W1)) u_dut1 (
        .CLK_SRC(clk), .RESET_N(rst_n), .SLOW_CS(slow_cs), .RUN(run), .STEP(step),
        .PHI0(phi[1]), .CYCLE_END(cend[1]), .HALTED(halted[1]), .STRETCHING(stretching[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: position t within the current PHI0 period, the period's slow flag, and a halted flag
    int m_t [2];
    bit m_slow [2];
    bit m_halt [2];
    bit m_stq;

    function automatic int div_of(input int i);
        return i == 0 ? D0 : D1;
    endfunction
    function automatic int wait_of(input int i);
        return i == 0 ? W0 : W1;
    endfunction
    function automatic int hi_len(input int i);
        return div_of(i) / 2 + ((m_slow[i] && wait_of(i) > 0) ? wait_of(i) : 0);
    endfunction
    function automatic int per_len(input int i);
        return hi_len(i) + div_of(i) - div_of(i) / 2;
    endfunction
    function automatic logic [3:0] exp_out(input int i);
        int hi = hi_len(i);
        int t = m_t[i];
        int hl = div_of(i) / 2;
        if (m_halt[i]) return 4'b0010;
        return {t < hi, t == hi, 1'b0, t >= hl && t < hi};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_t[i] <= 0;
                m_slow[i] <= 1'b0;
                m_halt[i] <= 1'b0;
            end
            m_stq <= 1'b0;
        end else begin
            m_stq <= step;
            for (int i = 0; i < 2; i++) begin
                if (m_halt[i]) begin
                    if (run || (step && !m_stq)) begin
                        m_halt[i] <= 1'b0;
                        m_t[i] <= 0;
                    end
                end else if (m_t[i] == per_len(i) - 1) begin
                    m_t[i] <= 0;
                    if (STEP_EN && !run) m_halt[i] <= 1'b1;
                end else begin
                    m_t[i] <= m_t[i] + 1;
                end
                if (!m_halt[i] && m_t[i] == 0) m_slow[i] <= slow_cs;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({phi[i], cend[i], halted[i], stretching[i]} !== exp_out(i)) begin
                errors++;
                $display("FAIL model dut%0d at %0t: phi/cend/halted/stretch got %b required %b",
                         i, $time, {phi[i], cend[i], halted[i], stretching[i]}, exp_out(i));
            end
        end
    end

    task automatic lit(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Skips to the next PHI0 rise, then counts one full period; returns just after the following rise
    task automatic measure(input int i, output int hi, output int lo, output int ce);
        int n = 0;
        hi = 0; lo = 0; ce = 0;
        @(negedge clk);
        while (phi[i] && n < 300) begin @(negedge clk); n++; end
        while (!phi[i] && n < 300) begin @(negedge clk); n++; end
        while (phi[i] && n < 300) begin hi++; @(negedge clk); n++; end
        while (!phi[i] && n < 300) begin lo++; ce += int'(cend[i]); @(negedge clk); n++; end
    endtask

    task automatic first_high(input int i, output int n);
        n = 0;
        @(negedge clk);
        while (phi[i] && n < 50) begin n++; @(negedge clk); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    int h, l, c, s, h1, b;
    initial begin
        rst_n = 1'b1; slow_cs = 1'b0; run = 1'b1; step = 1'b0;
        #1 rst_n = 1'b0;
        tick(3);
        lit("rst_phi", int'(phi), 3);
        lit("rst_cend", int'(cend), 0);
        lit("rst_halted", int'(halted), 0);
        lit("rst_stretch", int'(stretching), 0);
        @(posedge clk); #2 rst_n = 1'b1;
        first_high(0, h); lit("first_high0", h, 3);

        measure(0, h, l, c); lit("free0_hi", h, 3); lit("free0_lo", l, 3); lit("free0_ce", c, 1);
        measure(1, h, l, c); lit("free1_hi", h, 2); lit("free1_lo", l, 3); lit("free1_ce", c, 1);
        step = 1'b1; tick(2); step = 1'b0;

        slow_cs = 1'b1;
        measure(1, h, l, c); lit("nowait1_hi", h, 2); lit("nowait1_lo", l, 3);
        measure(0, h, l, c); lit("slow0_hi", h, 9); lit("slow0_lo", l, 3); lit("slow0_ce", c, 1);
        h = 1; s = 0;
        for (int k = 0; k < 11; k++) begin
            slow_cs = (k % 2 == 0);
            @(negedge clk);
            h += int'(phi[0]);
            s += int'(stretching[0]);
        end
        lit("toggle_hi", h, 9); lit("toggle_stretch", s, 6);
        slow_cs = 1'b0;

        measure(0, h, l, c); lit("fast0_hi", h, 3); lit("fast0_lo", l, 3);
        @(posedge clk); #1 run = 1'b0;
`ifdef CPU_CLK_STEP_EN
        h = 0; c = 0;
        repeat (30) begin @(negedge clk); h += int'(phi[0]); c += int'(cend[0]); end
        lit("halt_hi", h, 2); lit("halt_ce", c, 1);
        lit("halt_halted", int'(halted), 3); lit("halt_phi", int'(phi), 0);
        for (int r = 0; r < 2; r++) begin
            h = 0; c = 0; h1 = 0;
            for (int k = 0; k < 20; k++) begin
                step = (k < 5);
                @(negedge clk);
                h += int'(phi[0]); h1 += int'(phi[1]); c += int'(cend[0]);
            end
            lit("step_hi0", h, 3); lit("step_ce0", c, 1); lit("step_hi1", h1, 2);
            lit("step_rehalt", int'(halted), 3);
        end
        run = 1'b1;
        measure(0, h, l, c); lit("resume0_hi", h, 3); lit("resume0_lo", l, 3);
`else
        measure(0, h, l, c); lit("norun0_hi", h, 3); lit("norun0_lo", l, 3); lit("norun0_ce", c, 1);
        measure(1, h, l, c); lit("norun1_hi", h, 2); lit("norun1_lo", l, 3); lit("norun1_ce", c, 1);
        lit("norun_halted", int'(halted), 0);
        step = 1'b1; tick(3); step = 1'b0;
        measure(1, h, l, c); lit("nostep1_hi", h, 2); lit("nostep1_lo", l, 3);
        run = 1'b1;
`endif

        slow_cs = 1'b1;
        b = 0;
        while (!stretching[0] && b < 100) begin @(negedge clk); b++; end
        lit("saw_stretch", int'(stretching[0]), 1);
        @(posedge clk); #2 rst_n = 1'b0; #1;
        lit("midrst_phi", int'(phi[0]), 1);
        lit("midrst_stretch", int'(stretching[0]), 0);
        lit("midrst_cend", int'(cend[0]), 0);
        lit("midrst_halted", int'(halted[0]), 0);
        slow_cs = 1'b0;
        tick(2);
        @(posedge clk); #2 rst_n = 1'b1;
        first_high(0, h); lit("rel_high0", h, 3);
        measure(0, h, l, c); lit("rel0_hi", h, 3); lit("rel0_lo", l, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
